// File: rtl/write_arbiter_pkg.sv
//------------------------------------------------------------------------------
// write_arbiter_pkg : shared state encoding, default widths and helpers
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package write_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_XFER  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int c_NUM_PORTS  = 16;
   localparam int c_DATA_WIDTH = 64;
   localparam int c_PRI_WIDTH  = 3;
   localparam int c_LEN_WIDTH  = 7;

   // A single-port build still needs a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/write_arbiter_if.sv
//------------------------------------------------------------------------------
// write_arbiter_if : requester/segment-writer bundle around the write arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface write_arbiter_if #(
   parameter int NUM_PORTS  = write_arbiter_pkg::c_NUM_PORTS,
   parameter int DATA_WIDTH = write_arbiter_pkg::c_DATA_WIDTH,
   parameter int PRI_WIDTH  = write_arbiter_pkg::c_PRI_WIDTH,
   parameter int LEN_WIDTH  = write_arbiter_pkg::c_LEN_WIDTH
);
   import write_arbiter_pkg::*;

   localparam int IDX_W = idx_width(NUM_PORTS);

   logic [NUM_PORTS-1:0]            req;
   logic [NUM_PORTS*PRI_WIDTH-1:0]  req_pri;
   logic [NUM_PORTS-1:0]            port_valid;
   logic [NUM_PORTS*DATA_WIDTH-1:0] port_data;
   logic [NUM_PORTS-1:0]            port_eop;
   logic                            wr_busy;

   logic [NUM_PORTS-1:0]            port_ready;
   logic [NUM_PORTS-1:0]            grant;
   logic [IDX_W-1:0]                grant_idx;
   logic                            transfering;
   logic                            wr_valid;
   logic [DATA_WIDTH-1:0]           wr_data;
   logic                            wr_eop;
   logic [LEN_WIDTH-1:0]            pkt_beats;
   logic                            len_err;

   modport master (
      output req, req_pri, port_valid, port_data, port_eop, wr_busy,
      input  port_ready, grant, grant_idx, transfering,
             wr_valid, wr_data, wr_eop, pkt_beats, len_err
   );

   modport slave (
      input  req, req_pri, port_valid, port_data, port_eop, wr_busy,
      output port_ready, grant, grant_idx, transfering,
             wr_valid, wr_data, wr_eop, pkt_beats, len_err
   );

endinterface

`default_nettype wire

// File: rtl/write_arbiter_rr_pri_select.sv
//------------------------------------------------------------------------------
// rr_pri_select : combinational highest-priority pick, ties resolved round-robin
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_pri_select import write_arbiter_pkg::*; #(
   parameter int NUM_PORTS = c_NUM_PORTS,
   parameter int PRI_WIDTH = c_PRI_WIDTH,
   parameter int IDX_W     = idx_width(NUM_PORTS)
) (
   input  wire logic [NUM_PORTS-1:0]           req,
   input  wire logic [NUM_PORTS*PRI_WIDTH-1:0] req_pri,
   input  wire logic [IDX_W-1:0]               rr_ptr,
   output logic      [IDX_W-1:0]               winner,
   output logic                                valid
);

   logic [IDX_W:0]         w_sum;
   logic [IDX_W-1:0]       w_idx;
   logic [IDX_W-1:0]       w_winner;
   logic                   w_found;
   logic [PRI_WIDTH-1:0]   w_best_pri;

   // Scan starts at rr_ptr; strict '>' keeps the earliest port in scan order on ties.
   always_comb begin
      w_sum      = '0;
      w_idx      = '0;
      w_winner   = '0;
      w_found    = 1'b0;
      w_best_pri = '0;
      for (int off = 0; off < NUM_PORTS; off++) begin
         w_sum = {1'b0, rr_ptr} + (IDX_W+1)'(off);
         w_idx = (w_sum >= (IDX_W+1)'(NUM_PORTS)) ? IDX_W'(w_sum - (IDX_W+1)'(NUM_PORTS))
                                                  : IDX_W'(w_sum);
         if (req[w_idx] && (!w_found || (req_pri[w_idx*PRI_WIDTH +: PRI_WIDTH] > w_best_pri))) begin
            w_found    = 1'b1;
            w_winner   = w_idx;
            w_best_pri = req_pri[w_idx*PRI_WIDTH +: PRI_WIDTH];
         end
      end
   end

   assign winner = w_winner;
   assign valid  = w_found;

endmodule

`default_nettype wire

// File: rtl/write_arbiter.sv
//------------------------------------------------------------------------------
// write_arbiter : N:1 packet arbiter feeding a single segment-writer beat stream
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module write_arbiter import write_arbiter_pkg::*; #(
   parameter int NUM_PORTS  = c_NUM_PORTS,
   parameter int DATA_WIDTH = c_DATA_WIDTH,
   parameter int PRI_WIDTH  = c_PRI_WIDTH,
   parameter int LEN_WIDTH  = c_LEN_WIDTH
) (
   input  wire logic       clk,
   input  wire logic       rst,
   write_arbiter_if.slave  bus
);

   localparam int                   IDX_W         = idx_width(NUM_PORTS);
   localparam logic [LEN_WIDTH-1:0] c_MAX_BEATS   = '1;
   localparam logic [IDX_W-1:0]     c_LAST_PORT   = IDX_W'(NUM_PORTS - 1);

   state_t                  r_state;
   logic [IDX_W-1:0]        r_rr_ptr;
   logic [IDX_W-1:0]        r_owner;
   logic [NUM_PORTS-1:0]    r_grant;
   logic                    r_transfering;
   logic                    r_wr_valid;
   logic [DATA_WIDTH-1:0]   r_wr_data;
   logic                    r_wr_eop;
   logic [LEN_WIDTH-1:0]    r_pkt_beats;
   logic                    r_len_err;

   logic [IDX_W-1:0]        w_winner;
   logic                    w_win_valid;
   logic                    w_sel_valid;
   logic [DATA_WIDTH-1:0]   w_sel_data;
   logic                    w_sel_eop;
   logic                    w_xfer_open;
   logic                    w_accept;
   logic                    w_last_slot;

   rr_pri_select #(
      .NUM_PORTS (NUM_PORTS),
      .PRI_WIDTH (PRI_WIDTH),
      .IDX_W     (IDX_W)
   ) u_select (
      .req     (bus.req),
      .req_pri (bus.req_pri),
      .rr_ptr  (r_rr_ptr),
      .winner  (w_winner),
      .valid   (w_win_valid)
   );

   always_comb begin
      w_sel_valid = bus.port_valid[r_owner];
      w_sel_data  = bus.port_data[r_owner*DATA_WIDTH +: DATA_WIDTH];
      w_sel_eop   = bus.port_eop[r_owner];
   end

   // wr_busy gates ready combinationally so a beat offered while busy rises is never taken.
   assign w_xfer_open = (r_state == ST_XFER) && !bus.wr_busy;
   assign w_accept    = w_xfer_open && w_sel_valid;
   assign w_last_slot = (r_pkt_beats + LEN_WIDTH'(1)) == c_MAX_BEATS;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_rr_ptr      <= '0;
         r_owner       <= '0;
         r_grant       <= '0;
         r_transfering <= 1'b0;
         r_wr_valid    <= 1'b0;
         r_wr_data     <= '0;
         r_wr_eop      <= 1'b0;
         r_pkt_beats   <= '0;
         r_len_err     <= 1'b0;
      end else begin
         r_wr_valid <= 1'b0;
         r_wr_eop   <= 1'b0;
         r_len_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_win_valid) begin
                  r_owner <= w_winner;
                  r_grant <= NUM_PORTS'(1) << w_winner;
                  r_state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               r_transfering <= 1'b1;
               r_state       <= ST_XFER;
            end
            ST_XFER: begin
               if (w_accept) begin
                  r_wr_valid  <= 1'b1;
                  r_wr_data   <= w_sel_data;
                  r_wr_eop    <= w_sel_eop || w_last_slot;
                  r_len_err   <= !w_sel_eop && w_last_slot;
                  r_pkt_beats <= r_pkt_beats + LEN_WIDTH'(1);
                  if (w_sel_eop || w_last_slot) begin
                     r_transfering <= 1'b0;
                     r_state       <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               r_grant     <= '0;
               r_owner     <= '0;
               r_pkt_beats <= '0;
               r_rr_ptr    <= (r_owner == c_LAST_PORT) ? '0 : r_owner + IDX_W'(1);
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.port_ready  = w_xfer_open ? r_grant : '0;
   assign bus.grant       = r_grant;
   assign bus.grant_idx   = r_owner;
   assign bus.transfering = r_transfering;
   assign bus.wr_valid    = r_wr_valid;
   assign bus.wr_data     = r_wr_data;
   assign bus.wr_eop      = r_wr_eop;
   assign bus.pkt_beats   = r_pkt_beats;
   assign bus.len_err     = r_len_err;

endmodule

`default_nettype wire

// File: tb/tb_write_arbiter.sv
//------------------------------------------------------------------------------
// tb_write_arbiter : randomized scoreboard bench for write_arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_write_arbiter;
   import write_arbiter_pkg::*;

   localparam int NP   = 16;
   localparam int DW   = 64;
   localparam int PW   = 3;
   localparam int LW   = 7;
   localparam int MAXB = (1 << LW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   write_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .PRI_WIDTH(PW), .LEN_WIDTH(LW)) bus ();

   write_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .PRI_WIDTH(PW), .LEN_WIDTH(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [DW-1:0] data;
      bit            eop;
      int            beats;
      bit            lerr;
   } beat_t;

   int     errors = 0;
   int     checks = 0;
   int     cyc = 0;
   beat_t  sb[$];
   int     grant_log[$];

   // requester-side packet state
   bit          pend[NP];
   int          plen[NP];
   bit          noeop[NP];
   int          sent[NP];
   int          pri_v[NP];
   int          pkt_id[NP];
   int          reps[NP];
   logic [23:0] salt[NP];
   int          next_id = 0;

   // reference model of the write path owner
   bit m_busy = 1'b0;
   int m_owner = 0;
   int m_rr = 0;
   int m_free_cyc = 1 << 30;
   int m_xfer_cyc = 0;

   logic [NP-1:0]    drv_req = '0;
   logic [NP*PW-1:0] drv_pri = '0;
   logic [NP-1:0]    drv_valid = '0;
   int               valid_rate = 100;
   bit               junk_en = 1'b0;
   int               len_err_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] beat_data(input int p, input int b);
      return {8'(p), 16'(pkt_id[p]), 16'(b), salt[p]};
   endfunction

   function automatic int pick(input logic [NP-1:0] r, input logic [NP*PW-1:0] pr, input int rr);
      int best;
      int bp;
      best = -1;
      bp   = -1;
      for (int off = 0; off < NP; off++) begin
         int i;
         int pv;
         i  = (rr + off) % NP;
         pv = int'(pr[i*PW +: PW]);
         if (r[i] && pv > bp) begin
            best = i;
            bp   = pv;
         end
      end
      return best;
   endfunction

   function automatic bit any_pend();
      for (int p = 0; p < NP; p++)
         if (pend[p] || reps[p] > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic start_pkt(input int p, input int pri, input int len, input bit ne);
      pend[p]   = 1'b1;
      pri_v[p]  = pri;
      plen[p]   = len;
      noeop[p]  = ne;
      sent[p]   = 0;
      pkt_id[p] = next_id++;
      salt[p]   = 24'($urandom);
   endtask

   task automatic clear_inputs();
      bus.req        = '0;
      bus.req_pri    = '0;
      bus.port_valid = '0;
      bus.port_data  = '0;
      bus.port_eop   = '0;
      bus.wr_busy    = 1'b0;
      drv_req        = '0;
      drv_pri        = '0;
      drv_valid      = '0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_grant"}, bus.grant, 0);
      chk({tag, "_grant_idx"}, bus.grant_idx, 0);
      chk({tag, "_port_ready"}, bus.port_ready, 0);
      chk({tag, "_transfering"}, bus.transfering, 0);
      chk({tag, "_wr_valid"}, bus.wr_valid, 0);
      chk({tag, "_wr_data"}, bus.wr_data, 0);
      chk({tag, "_wr_eop"}, bus.wr_eop, 0);
      chk({tag, "_pkt_beats"}, bus.pkt_beats, 0);
      chk({tag, "_len_err"}, bus.len_err, 0);
   endtask

   // One cycle: drive at negedge, check ready, record the beat the model says is taken.
   task automatic step(input bit busy);
      logic [NP-1:0] exp_rdy;
      bit            exp_tr;
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
         if (!pend[p] && reps[p] > 0) begin
            reps[p]--;
            start_pkt(p, pri_v[p], plen[p], noeop[p]);
         end
      end
      for (int p = 0; p < NP; p++) begin
         bit v;
         bit own;
         own = m_busy && (m_owner == p) && (cyc >= m_xfer_cyc);
         v   = pend[p] && ($urandom_range(99) < valid_rate);
         bus.port_valid[p]           = v || (!pend[p] && junk_en && ($urandom_range(3) == 0));
         bus.port_data[p*DW +: DW]   = pend[p] ? beat_data(p, sent[p]) : {$urandom, $urandom};
         bus.port_eop[p]             = pend[p] ? (!noeop[p] && (sent[p] == plen[p] - 1)) : 1'($urandom);
         bus.req[p]                  = pend[p] && !(own && $urandom_range(1) == 1);
         bus.req_pri[p*PW +: PW]     = pend[p] ? PW'(pri_v[p]) : PW'($urandom);
      end
      bus.wr_busy = busy;
      drv_req     = bus.req;
      drv_pri     = bus.req_pri;
      drv_valid   = bus.port_valid;
      #1;
      exp_tr  = m_busy && (cyc >= m_xfer_cyc);
      exp_rdy = (exp_tr && !busy) ? (NP'(1) << m_owner) : '0;
      chk("port_ready", bus.port_ready, exp_rdy);
      chk("transfering", bus.transfering, exp_tr);
      if (exp_rdy != '0 && drv_valid[m_owner]) begin
         int    p;
         int    b;
         bit    last;
         bit    trunc;
         beat_t e;
         p     = m_owner;
         b     = sent[p];
         last  = !noeop[p] && (b == plen[p] - 1);
         trunc = !last && (b + 1 == MAXB);
         e.data  = beat_data(p, b);
         e.eop   = last || trunc;
         e.beats = b + 1;
         e.lerr  = trunc;
         sb.push_back(e);
         sent[p]++;
         if (last || trunc) begin
            pend[p]    = 1'b0;
            m_busy     = 1'b0;
            m_rr       = (p + 1) % NP;
            m_free_cyc = cyc + 3;
         end
      end
   endtask

   task automatic run_until_idle(input int maxc, input string tag, input int busy_pct);
      int n;
      n = 0;
      while ((any_pend() || m_busy) && n < maxc) begin
         step($urandom_range(99) < busy_pct);
         n++;
      end
      chk({tag, "_completed"}, any_pend() || m_busy, 0);
      step(1'b0);
      step(1'b0);
      chk({tag, "_sb_drain"}, sb.size(), 0);
   endtask

   task automatic do_reset(input string tag);
      #1;
      rst = 1'b0;
      clear_inputs();
      #1;
      check_zero(tag);
      sb.delete();
      m_busy = 1'b0;
      m_rr   = 0;
      for (int p = 0; p < NP; p++) begin
         pend[p] = 1'b0;
         reps[p] = 0;
      end
      repeat (2) @(negedge clk);
      rst        = 1'b1;
      m_free_cyc = cyc + 1;
   endtask

   // Monitor: arbitration decisions and output beats against the model.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            if (!m_busy && cyc >= m_free_cyc && drv_req != '0) begin
               int w;
               w = pick(drv_req, drv_pri, m_rr);
               chk("grant_onehot", bus.grant, NP'(1) << w);
               chk("grant_idx", bus.grant_idx, w);
               m_busy     = 1'b1;
               m_owner    = w;
               m_xfer_cyc = cyc + 1;
               grant_log.push_back(w);
            end else if (!m_busy && cyc + 1 >= m_free_cyc) begin
               chk("grant_idle", bus.grant, 0);
               chk("grant_idx_idle", bus.grant_idx, 0);
            end else if (m_busy) begin
               chk("grant_held", bus.grant, NP'(1) << m_owner);
            end
            if (bus.wr_valid) begin
               if (sb.size() == 0) begin
                  chk("wr_valid_unexpected", bus.wr_valid, 0);
               end else begin
                  beat_t e;
                  e = sb.pop_front();
                  chk("wr_data", bus.wr_data, e.data);
                  chk("wr_eop", bus.wr_eop, e.eop);
                  chk("pkt_beats", bus.pkt_beats, e.beats);
                  chk("len_err", bus.len_err, e.lerr);
                  if (bus.len_err) len_err_seen++;
               end
            end else begin
               chk("len_err_idle", bus.len_err, 0);
            end
         end
      end
   end

   initial begin
      int base;
      int le0;
      int n;
      clear_inputs();
      for (int p = 0; p < NP; p++) begin
         pend[p] = 1'b0;
         reps[p] = 0;
         sent[p] = 0;
      end
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst        = 1'b1;
      m_free_cyc = cyc + 1;

      // single port, four beats
      start_pkt(3, 2, 4, 1'b0);
      run_until_idle(50, "single", 0);
      chk("single_owner", grant_log[grant_log.size()-1], 3);

      // priority beats port order
      base = grant_log.size();
      start_pkt(2, 1, 3, 1'b0);
      start_pkt(9, 5, 3, 1'b0);
      run_until_idle(60, "prio", 0);
      chk("prio_first", grant_log[base], 9);
      chk("prio_second", grant_log[base+1], 2);

      // round robin with wrap, fresh pointer
      do_reset("rr_reset");
      base = grant_log.size();
      start_pkt(0, 4, 2, 1'b0);  reps[0] = 1;
      start_pkt(5, 4, 2, 1'b0);  reps[5] = 1;
      start_pkt(15, 4, 2, 1'b0); reps[15] = 1;
      run_until_idle(100, "rr", 0);
      chk("rr_0", grant_log[base], 0);
      chk("rr_1", grant_log[base+1], 5);
      chk("rr_2", grant_log[base+2], 15);
      chk("rr_3", grant_log[base+3], 0);

      // stall mid-packet
      start_pkt(6, 3, 8, 1'b0);
      n = 0;
      while (sent[6] < 3 && n < 30) begin
         step(1'b0);
         n++;
      end
      chk("stall_reach", sent[6], 3);
      repeat (3) step(1'b1);
      chk("stall_hold", sent[6], 3);
      run_until_idle(60, "stall", 0);

      // overlength truncation
      le0 = len_err_seen;
      start_pkt(4, 7, 130, 1'b1);
      run_until_idle(400, "overlen", 0);
      chk("overlen_beats", sent[4], MAXB);
      chk("overlen_len_err", len_err_seen, le0 + 1);

      // reset during beat 2, then a fresh request
      start_pkt(7, 1, 6, 1'b0);
      n = 0;
      while (sent[7] < 1 && n < 30) begin
         step(1'b0);
         n++;
      end
      do_reset("rst_mid");
      start_pkt(1, 0, 3, 1'b0);
      run_until_idle(60, "post_rst", 0);
      chk("post_rst_owner", grant_log[grant_log.size()-1], 1);

      // randomized traffic
      valid_rate = 75;
      junk_en    = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         for (int p = 0; p < NP; p++)
            if (!pend[p] && reps[p] == 0 && $urandom_range(99) < 3)
               start_pkt(p, $urandom_range(7), $urandom_range(1, 8), 1'b0);
         step($urandom_range(3) == 0);
      end
      run_until_idle(3000, "random", 25);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
